imem_loader: RTL

- Write-side companion to the core's instruction memory.
- Accepts a byte stream (boot/host link) over a valid/ready handshake and assembles little-endian 32-bit words.
- Issues one-cycle word writes into instruction memory at sequential word addresses.
- Holds the core in reset until the whole image is written.

---
 rtl/imem_loader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: assembles a byte stream into 32-bit little-endian words and
// writes them sequentially into instruction memory, holding the core in reset
// until the whole image has landed.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing XOR checksum byte).
module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_rst_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [16:0]       DEPTH = 17'd1 << ADDR_W;
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [1:0]          bidx_q, bidx_d;
    logic [15:0]         wcnt_q, wcnt_d;
    logic [31:0]         word_q, word_d;
    logic [7:0]          csum_q, csum_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wd_q, wd_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                accept;
    logic [15:0]         n_full;

    assign accept    = in_valid && in_ready;
    assign n_full    = {in_data, len_q[7:0]};
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wd    = wd_q;
    assign done      = done_q;
    assign err       = err_q;
    // Core leaves reset together with done, i.e. one cycle after the last write.
    assign cpu_rst_n = done_q;

    // Handshake and busy are pure functions of state.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            S_LEN0, S_LEN1, S_DATA: begin in_ready = 1'b1; busy = 1'b1; end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:                  begin in_ready = 1'b1; busy = 1'b1; end
`endif
            default: ;
        endcase
    end

    // Next-state logic: length parse, word assembly, write strobe generation.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        bidx_d  = bidx_q;
        wcnt_d  = wcnt_q;
        word_d  = word_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        wd_d    = wd_q;
        // Address advances the cycle after each write; wraps modulo depth.
        addr_d  = we_q ? addr_q + 1'b1 : addr_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN0;
                    len_d   = '0;
                    bidx_d  = '0;
                    wcnt_d  = '0;
                    word_d  = '0;
                    csum_d  = '0;
                    addr_d  = BASE;
                end
            end
            S_LEN0: begin
                if (accept) begin
                    len_d[7:0] = in_data;
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    len_d[15:8] = in_data;
                    if (n_full == 16'd0 || {1'b0, n_full} > DEPTH) state_d = S_ERR;
                    else                                          state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_d[{bidx_q, 3'b000} +: 8] = in_data;
                    csum_d = csum_q ^ in_data;
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        we_d   = 1'b1;
                        wd_d   = {in_data, word_q[23:0]};
                        wcnt_d = wcnt_q + 16'd1;
                        if (wcnt_q == len_q - 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state_d = S_CHK;
`else
                            state_d = S_DONE;
`endif
                        end
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (accept) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
        // done lags DONE entry by one cycle so the final write retires first.
        done_d = (state_q == S_DONE) && (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            bidx_q  <= '0;
            wcnt_q  <= '0;
            word_q  <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= BASE;
            wd_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            bidx_q  <= bidx_d;
            wcnt_q  <= wcnt_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule
